dma_stream_ctrl: RTL and testbench
==================================

DMA_STREAM_CTRL -- requirements
Module: dma_stream_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of both memory ports.
REQ-002 Parameter LEN_W, default 7, width of length fields and word counters (max 64 words).
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_start  in  1  one-cycle job request; ignored while busy=1.
REQ-006 cfg_mode  in  3  one-hot kernel select: 001 FIR, 010 matmul, 100 sort.
REQ-007 cfg_src_addr / cfg_dst_addr  in  ADDR_W  first read / first write word address.
REQ-008 cfg_len_in / cfg_len_out  in  LEN_W  words to stream to / collect from accelerator.
REQ-009 busy  out  1  job in progress; done  out  1  one-cycle completion pulse; err  out  1  sticky tlast error.
REQ-010 mem_rd_en  out  1; mem_rd_addr  out  ADDR_W; mem_rd_data  in  32, valid exactly one cycle after mem_rd_en.
REQ-011 mem_wr_en  out  1; mem_wr_addr  out  ADDR_W; mem_wr_data  out  32.
REQ-012 ap_start  out  3; ap_idle  in  1; ap_done  in  3 (accelerator control).
REQ-013 tx_tvalid/tx_tdata[31:0]/tx_tlast  out, tx_tready  in  -- stream master into accelerator.
REQ-014 rx_tvalid/rx_tdata[31:0]/rx_tlast  in, rx_tready  out  -- stream slave from accelerator.

Function
REQ-015 FSM states IDLE, LAUNCH, RUN, FINISH; IDLE->LAUNCH on cfg_start with busy=0; cfg_* latched that cycle.
REQ-016 LAUNCH: ap_start=latched mode for exactly one cycle in which ap_idle=1, then RUN; waits while ap_idle=0.
REQ-017 cfg_mode not one-hot: job still completes, ap_start never asserted, done pulses next cycle, no memory access.
REQ-018 RUN: TX and RX proceed concurrently and independently.
REQ-019 TX: reads addresses src..src+len_in-1 in order into a 2-entry skid buffer; mem_rd_en only when an entry is free counting in-flight reads.
REQ-020 tx_tvalid=buffer non-empty; transfer on tx_tvalid&tx_tready; tx_tdata/tx_tvalid stable while stalled.
REQ-021 tx_tlast=1 only on word len_in-1; len_in=0 means TX complete immediately, no reads, no tx_tvalid.
REQ-022 Sustained throughput 1 word/cycle when tx_tready held high, after 2-cycle initial read latency.
REQ-023 RX: rx_tready=1 in RUN while rx count<len_out; each rx handshake writes rx_tdata to dst+count same cycle (mem_wr_en combinational on handshake).
REQ-024 Address arithmetic wraps modulo 2^ADDR_W; counters never exceed their length.
REQ-025 ap_done!=0 during RUN sets sticky acc_done flag; RUN->FINISH when TX complete, RX count=len_out and acc_done (or ap_done same cycle).
REQ-026 FINISH: done=1 one cycle, busy drops, ->IDLE; cfg_start in that cycle ignored.
REQ-027 rx_tvalid outside RUN or after len_out reached: rx_tready=0, no write.

Reset
REQ-028 rst: state IDLE; busy, done, err, ap_start, mem_rd_en, mem_wr_en, tx_tvalid, tx_tlast, rx_tready = 0; addresses/data 0; buffer emptied.
REQ-029 rst mid-job aborts; read data returning the cycle after rst is discarded.

Configuration
REQ-030 Macro DMA_TLAST_CHECK_EN defined: err sets when rx_tlast disagrees with (count==len_out-1) on an rx handshake; cleared only by rst or next cfg_start.
REQ-031 Macro undefined: rx_tlast ignored, err tied 0.

Structure
REQ-032 Package dma_pkg: FSM state enum, mode one-hot constants, LEN_W/ADDR_W defaults.
REQ-033 One sub-module dma_tx_skid: 2-entry buffer with occupancy count used for read gating.

Verification
REQ-034 FIR, len_in=64 len_out=64, src=0x000 dst=0x100, ready always 1 -> 64 tx beats, tlast on beat 63, mem[0x100..0x13F]=echo data, one done pulse.
REQ-035 Sort, len_in=len_out=10, tx_tready toggled every cycle -> tdata stable across stalls, no duplicate/lost word, order preserved.
REQ-036 ap_idle=0 for 5 cycles after cfg_start -> ap_start held 0, then exactly one pulse of 100.
REQ-037 src=0xFFE len_in=4 -> reads 0xFFE,0xFFF,0x000,0x001.
REQ-038 rst asserted mid-RUN (word 7 of 16) -> all outputs 0 next cycle; new job runs clean.
REQ-039 DMA_TLAST_CHECK_EN, rx_tlast on word 5 of 16 -> err=1 persists; macro undefined -> err=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA stream controller: FSM states,
// one-hot kernel select codes and default port widths.
package dma_pkg;

    localparam int DMA_ADDR_W = 12;
    localparam int DMA_LEN_W  = 7;

    localparam logic [2:0] MODE_FIR    = 3'b001;
    localparam logic [2:0] MODE_MATMUL = 3'b010;
    localparam logic [2:0] MODE_SORT   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } dma_state_e;

    // A job only talks to the accelerator when exactly one kernel is selected.
    function automatic logic mode_is_valid(input logic [2:0] mode);
        return (mode == MODE_FIR) || (mode == MODE_MATMUL) || (mode == MODE_SORT);
    endfunction

endpackage

// File: rtl/dma_tx_skid.sv
// Two-entry FIFO between the memory read port and the TX stream.
// The occupancy count is exported so the parent can throttle reads.
module dma_tx_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [31:0] i_push_data,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [1:0]  o_count
);

    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic [1:0]  r_count;
    logic        w_pop;

    // A pop on an empty buffer is meaningless and is dropped here.
    assign w_pop = i_pop && (r_count != 2'd0);

    // Entry 0 is always the head; entry 1 only holds data when two are queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_data0 <= i_push_data;
                    else                 r_data1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= i_push_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_data0 : '0;
    assign o_count = r_count;

endmodule

// File: rtl/dma_stream_ctrl.sv
// DMA stream controller: launches an accelerator kernel, streams len_in
// words from memory into it and writes len_out returned words to memory.
// Optional build macro DMA_TLAST_CHECK_EN enables the sticky rx_tlast check
// on err; without it rx_tlast is ignored and err is tied low.
//
// Handshakes: a stream beat transfers on the rising edge where tvalid and
// tready are both high; tvalid/tdata/tlast are held stable while tready is low.
module dma_stream_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [2:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [LEN_W-1:0]  cfg_len_in,
    input  logic [LEN_W-1:0]  cfg_len_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [2:0]        ap_start,
    input  logic              ap_idle,
    input  logic [2:0]        ap_done,
    output logic              tx_tvalid,
    output logic [31:0]       tx_tdata,
    output logic              tx_tlast,
    input  logic              tx_tready,
    input  logic              rx_tvalid,
    input  logic [31:0]       rx_tdata,
    input  logic              rx_tlast,
    output logic              rx_tready,
    output logic [1:0]        dbg_state
);

    dma_state_e        r_state;
    dma_state_e        w_next;

    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len_in;
    logic [LEN_W-1:0]  r_len_out;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  r_tx_cnt;
    logic [LEN_W-1:0]  r_rx_cnt;
    logic              r_rd_pend;
    logic              r_acc_done;

    logic              w_start_acc;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_rx_hs;
    logic              w_tx_done;
    logic              w_rx_done;
    logic              w_skid_valid;
    logic [31:0]       w_skid_data;
    logic [1:0]        w_skid_cnt;
    logic [2:0]        w_tx_occ;

    assign w_start_acc = (r_state == ST_IDLE) && cfg_start;
    assign w_tx_done   = (r_tx_cnt == r_len_in);
    assign w_rx_done   = (r_rx_cnt == r_len_out);

    // The read issued last cycle returns now and is pushed at this edge.
    dma_tx_skid u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_rd_pend),
        .i_push_data (mem_rd_data),
        .i_pop       (w_pop),
        .o_valid     (w_skid_valid),
        .o_data      (w_skid_data),
        .o_count     (w_skid_cnt)
    );

    assign w_pop = w_skid_valid && tx_tready;

    // Occupancy after this edge, counting the read already in flight; a
    // same-cycle pop frees a slot so reads sustain one word per cycle.
    assign w_tx_occ = 3'(w_skid_cnt) + 3'(r_rd_pend) - 3'(w_pop);
    assign w_rd_en  = (r_state == ST_RUN) && (r_rd_cnt < r_len_in) && (w_tx_occ < 3'd2);

    assign tx_tvalid   = w_skid_valid;
    assign tx_tdata    = w_skid_data;
    assign tx_tlast    = w_skid_valid && (r_tx_cnt == r_len_in - LEN_W'(1));

    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = w_rd_en ? (r_src + ADDR_W'(r_rd_cnt)) : '0;

    assign rx_tready   = (r_state == ST_RUN) && (r_rx_cnt < r_len_out);
    assign w_rx_hs     = rx_tvalid && rx_tready;
    assign mem_wr_en   = w_rx_hs;
    assign mem_wr_addr = w_rx_hs ? (r_dst + ADDR_W'(r_rx_cnt)) : '0;
    assign mem_wr_data = w_rx_hs ? rx_tdata : '0;

    assign dbg_state   = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and control outputs; busy is low in FINISH alongside done.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        ap_start = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                busy = 1'b1;
                if (!mode_is_valid(r_mode)) begin
                    w_next = ST_FINISH;
                end else if (ap_idle) begin
                    ap_start = r_mode;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_tx_done && w_rx_done && (r_acc_done || (ap_done != 3'b000)))
                    w_next = ST_FINISH;
            end
            ST_FINISH: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Job configuration capture, word counters and accelerator-done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len_in   <= '0;
            r_len_out  <= '0;
            r_rd_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_rd_pend  <= 1'b0;
            r_acc_done <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_start_acc) begin
                r_mode     <= cfg_mode;
                r_src      <= cfg_src_addr;
                r_dst      <= cfg_dst_addr;
                r_len_in   <= cfg_len_in;
                r_len_out  <= cfg_len_out;
                r_rd_cnt   <= '0;
                r_tx_cnt   <= '0;
                r_rx_cnt   <= '0;
                r_acc_done <= 1'b0;
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + LEN_W'(1);
                if (w_pop)   r_tx_cnt <= r_tx_cnt + LEN_W'(1);
                if (w_rx_hs) r_rx_cnt <= r_rx_cnt + LEN_W'(1);
                if ((r_state == ST_RUN) && (ap_done != 3'b000)) r_acc_done <= 1'b1;
            end
        end
    end

`ifdef DMA_TLAST_CHECK_EN
    logic r_err;

    // Sticky flag: tlast must mark exactly the last expected RX word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_rx_hs && (rx_tlast != (r_rx_cnt == r_len_out - LEN_W'(1)))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_rx_tlast;

    assign w_unused_rx_tlast = rx_tlast;
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_dma_stream_ctrl.sv
// Directed bench for dma_stream_ctrl: memory and echo-accelerator models,
// a TX scoreboard queue and immediate-assertion checks.
module tb_dma_stream_ctrl;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [2:0]        cfg_mode = '0;
    logic [ADDR_W-1:0] cfg_src_addr = '0;
    logic [ADDR_W-1:0] cfg_dst_addr = '0;
    logic [LEN_W-1:0]  cfg_len_in = '0;
    logic [LEN_W-1:0]  cfg_len_out = '0;
    logic              busy, done, err;
    logic              mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]       mem_rd_data = '0;
    logic [31:0]       mem_wr_data;
    logic [2:0]        ap_start;
    logic              ap_idle = 1'b1;
    logic [2:0]        ap_done = '0;
    logic              tx_tvalid, tx_tlast;
    logic [31:0]       tx_tdata;
    logic              tx_tready = 1'b1;
    logic              rx_tvalid, rx_tlast, rx_tready;
    logic [31:0]       rx_tdata;
    logic [1:0]        dbg_state;

    // Bench controls
    logic mem_init = 1'b1;
    logic clr_model = 1'b0;
    logic tog_en = 1'b0;
    int   acc_n_out = 0;
    int   tlast_idx = 0;

    // Model state
    logic [31:0]       mem [0:4095];
    logic [31:0]       acc_buf [0:127];
    logic [31:0]       tx_log [0:127];
    logic              tx_last_log [0:127];
    int                tx_cyc [0:127];
    logic [ADDR_W-1:0] rd_log [0:255];
    int   cyc = 0, rd_n = 0, wr_n = 0, tx_n = 0, acc_rd = 0;
    int   ap_start_n = 0, done_n = 0, stall_viol = 0;
    logic [2:0]  ap_start_val = '0;
    logic        saw_start = 1'b0, acc_fin = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dma_stream_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
        .cfg_len_in(cfg_len_in), .cfg_len_out(cfg_len_out),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .dbg_state(dbg_state)
    );

    // Echo accelerator: returns TX words in order on RX.
    assign rx_tvalid = (acc_rd < tx_n);
    assign rx_tdata  = acc_buf[acc_rd[6:0]];
    assign rx_tlast  = rx_tvalid && (acc_rd == tlast_idx);

    function automatic logic [31:0] mem_pat(input logic [ADDR_W-1:0] a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    // Memory, accelerator and logging model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int a = 0; a < 4096; a++) mem[a] <= mem_pat(ADDR_W'(a));
        end
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (rst || clr_model) begin
            rd_n <= 0; wr_n <= 0; tx_n <= 0; acc_rd <= 0;
            ap_start_n <= 0; ap_start_val <= '0; done_n <= 0; stall_viol <= 0;
            saw_start <= 1'b0; acc_fin <= 1'b0; prev_stall <= 1'b0; prev_data <= '0;
            ap_done <= '0; tx_tready <= 1'b1;
        end else begin
            tx_tready <= tog_en ? ~tx_tready : 1'b1;
            if (mem_rd_en) begin
                rd_log[rd_n[7:0]] <= mem_rd_addr;
                rd_n <= rd_n + 1;
            end
            if (mem_wr_en) wr_n <= wr_n + 1;
            if (ap_start != 3'b000) begin
                ap_start_n <= ap_start_n + 1;
                ap_start_val <= ap_start;
                saw_start <= 1'b1;
            end
            if (done) done_n <= done_n + 1;
            if (tx_tvalid && tx_tready && tx_n < 128) begin
                tx_log[tx_n[6:0]] <= tx_tdata;
                tx_last_log[tx_n[6:0]] <= tx_tlast;
                tx_cyc[tx_n[6:0]] <= cyc;
                acc_buf[tx_n[6:0]] <= tx_tdata;
                tx_n <= tx_n + 1;
            end
            if (prev_stall && !(tx_tvalid && tx_tdata == prev_data)) stall_viol <= stall_viol + 1;
            prev_stall <= tx_tvalid && !tx_tready;
            prev_data <= tx_tdata;
            if (rx_tvalid && rx_tready) acc_rd <= acc_rd + 1;
            ap_done <= '0;
            if (saw_start && !acc_fin && acc_rd == acc_n_out) begin
                ap_done <= 3'b001;
                acc_fin <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [2:0] mode, input logic [ADDR_W-1:0] src,
                             input logic [ADDR_W-1:0] dst, input int lin, input int lout,
                             input int tl);
        @(negedge clk);
        clr_model = 1'b1;
        acc_n_out = lout;
        tlast_idx = tl;
        @(negedge clk);
        clr_model    = 1'b0;
        cfg_mode     = mode;
        cfg_src_addr = src;
        cfg_dst_addr = dst;
        cfg_len_in   = LEN_W'(lin);
        cfg_len_out  = LEN_W'(lout);
        cfg_start    = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Waits for done; optionally pokes cfg_start during FINISH, which must be ignored.
    task automatic wait_done(input string nm, input int budget, input bit poke);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        if (poke) cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (poke) begin
            check({nm, "_finish_start_state"}, 32'(dbg_state), 32'd0);
            check({nm, "_finish_start_busy"}, 32'(busy), 32'd0);
        end
        @(negedge clk);
        check({nm, "_done_pulses"}, 32'(done_n), 32'd1);
    endtask

    task automatic verify_job(input string nm, input logic [ADDR_W-1:0] src,
                              input logic [ADDR_W-1:0] dst, input int lin, input int lout);
        logic [ADDR_W-1:0] a;
        check({nm, "_tx_beats"}, 32'(tx_n), 32'(lin));
        check({nm, "_rd_count"}, 32'(rd_n), 32'(lin));
        check({nm, "_wr_count"}, 32'(wr_n), 32'(lout));
        for (int i = 0; i < lin; i++) begin
            a = src + ADDR_W'(i);
            exp_q.push_back(mem_pat(a));
        end
        for (int i = 0; i < lin; i++) begin
            check($sformatf("%s_tdata_%0d", nm, i), tx_log[i], exp_q.pop_front());
            check($sformatf("%s_tlast_%0d", nm, i), 32'(tx_last_log[i]), 32'(i == lin - 1));
        end
        for (int i = 0; i < lout; i++) begin
            a = dst + ADDR_W'(i);
            check($sformatf("%s_mem_%0d", nm, i), mem[a], mem_pat(src + ADDR_W'(i)));
        end
    endtask

    task automatic check_all_low(input string nm);
        check({nm, "_state"}, 32'(dbg_state), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_ap_start"}, 32'(ap_start), 32'd0);
        check({nm, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({nm, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        check({nm, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({nm, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
        check({nm, "_wr_data"}, mem_wr_data, 32'd0);
        check({nm, "_tx_tvalid"}, 32'(tx_tvalid), 32'd0);
        check({nm, "_tx_tlast"}, 32'(tx_tlast), 32'd0);
        check({nm, "_tx_tdata"}, tx_tdata, 32'd0);
        check({nm, "_rx_tready"}, 32'(rx_tready), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] wrap_exp [0:3];
        logic              err_exp;
`ifdef DMA_TLAST_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF;
        wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_all_low("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIR 64 words, ready always high, cfg_start poked during FINISH
        start_job(3'b001, 12'h000, 12'h100, 64, 64, 63);
        wait_done("fir", 400, 1'b1);
        verify_job("fir", 12'h000, 12'h100, 64, 64);
        check("fir_ap_start_n", 32'(ap_start_n), 32'd1);
        check("fir_ap_start_val", 32'(ap_start_val), 32'b001);
        check("fir_throughput", 32'(tx_cyc[63] - tx_cyc[0]), 32'd63);
        check("fir_err", 32'(err), 32'd0);

        // Sort 10 words, ap_idle low for 5 cycles, tx_tready toggling
        ap_idle = 1'b0;
        tog_en  = 1'b1;
        start_job(3'b100, 12'h040, 12'h200, 10, 10, 9);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("sort_launch_hold_%0d", k), 32'(ap_start), 32'd0);
            check($sformatf("sort_launch_state_%0d", k), 32'(dbg_state), 32'd1);
            @(negedge clk);
        end
        ap_idle = 1'b1;
        wait_done("sort", 200, 1'b0);
        tog_en = 1'b0;
        verify_job("sort", 12'h040, 12'h200, 10, 10);
        check("sort_ap_start_n", 32'(ap_start_n), 32'd1);
        check("sort_ap_start_val", 32'(ap_start_val), 32'b100);
        check("sort_stall_stable", 32'(stall_viol), 32'd0);

        // Source address wraparound
        start_job(3'b010, 12'hFFE, 12'h300, 4, 4, 3);
        wait_done("wrap", 100, 1'b0);
        verify_job("wrap", 12'hFFE, 12'h300, 4, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap_rd_addr_%0d", i), 32'(rd_log[i]), 32'(wrap_exp[i]));

        // Non-one-hot mode: completes with no accelerator or memory activity
        start_job(3'b011, 12'h010, 12'h310, 4, 4, 3);
        wait_done("badmode", 6, 1'b0);
        check("badmode_ap_start_n", 32'(ap_start_n), 32'd0);
        check("badmode_rd_n", 32'(rd_n), 32'd0);
        check("badmode_wr_n", 32'(wr_n), 32'd0);
        check("badmode_tx_n", 32'(tx_n), 32'd0);

        // Zero-length job
        start_job(3'b001, 12'h020, 12'h320, 0, 0, 0);
        wait_done("zero", 20, 1'b0);
        check("zero_rd_n", 32'(rd_n), 32'd0);
        check("zero_tx_n", 32'(tx_n), 32'd0);
        check("zero_ap_start_n", 32'(ap_start_n), 32'd1);

        // Early rx_tlast on word 5 of 16
        start_job(3'b001, 12'h050, 12'h340, 16, 16, 5);
        wait_done("tlast", 200, 1'b0);
        verify_job("tlast", 12'h050, 12'h340, 16, 16);
        check("tlast_err", 32'(err), 32'(err_exp));
        repeat (3) @(negedge clk);
        check("tlast_err_sticky", 32'(err), 32'(err_exp));

        // Reset in the middle of RUN at word 7 of 16
        start_job(3'b001, 12'h060, 12'h380, 16, 16, 15);
        check("rstjob_err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 200; i++) begin
            if (tx_n >= 7) break;
            @(negedge clk);
        end
        check("rstjob_reached_word7", 32'(tx_n == 7), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_low("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("postrst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        // Clean job after the abort
        start_job(3'b001, 12'h070, 12'h3A0, 16, 16, 15);
        wait_done("after", 200, 1'b0);
        verify_job("after", 12'h070, 12'h3A0, 16, 16);
        check("after_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
